regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//   Parametrised multi-read-port register file for the datapath.
//   Width, depth and read-port count are configurable; register 0 can be hardwired to zero.
//   Supports optional write-to-read bypass and a sequenced bulk-clear engine with a busy/done handshake.
//   Sits between writeback (WriteData/WriteRegister) and the operand-fetch stage (ReadData*).
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; depth DEPTH = 2**ADDR_W
//   NUM_RD    2   number of independent read ports (>=1)
//   ZERO_REG  1   1: entry 0 reads 0, writes to it are dropped; 0: entry 0 is an ordinary register
//   BYPASS    1   1: a read of the address being written this cycle returns WriteData
// PORTS
//   clk            in   1              rising-edge clock
//   rst_n          in   1              async active-low reset
//   RegWrite       in   1              write enable, sampled at posedge clk
//   WriteRegister  in   ADDR_W         write address
//   WriteData      in   DATA_W         write data
//   ReadRegister   in   NUM_RD*ADDR_W  packed read addresses; port p = [p*ADDR_W +: ADDR_W]
//   ReadData       out  NUM_RD*DATA_W  packed read data; port p = [p*DATA_W +: DATA_W]
//   clr_req        in   1              request bulk clear; sampled at posedge clk
//   clr_busy       out  1              high while the clear sequence runs
//   clr_done       out  1              one-cycle pulse when the clear finishes
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     all entries = 0, FSM = IDLE, clr_busy = 0, clr_done = 0.
//     Deassertion takes effect at the next posedge.
//   Write:
//     At posedge, when RegWrite=1, clr_busy=0 and !(ZERO_REG && WriteRegister==0): mem[WriteRegister] <= WriteData.
//     New value is visible on non-bypassed reads from the following cycle.
//   Read:
//     Combinational, zero latency. ReadData[p] = mem[ReadRegister[p]].
//     If ZERO_REG and the address is 0, the port returns 0.
//     Bypass: if BYPASS=1, RegWrite=1, clr_busy=0, the write is not dropped and ReadRegister[p]==WriteRegister,
//     then ReadData[p] = WriteData in the same cycle. All ports are independent.
//     Ports reading the same address return identical data.
//   Clear FSM (IDLE, CLEAR, DONE):
//     IDLE -> CLEAR when clr_req=1. Index idx <= 0. clr_busy=1 from the next cycle.
//     CLEAR: each posedge mem[idx] <= 0, idx++. When idx == DEPTH-1 -> DONE.
//       Exactly DEPTH cycles; idx wraps to 0.
//     DONE: clr_done=1 for one cycle, clr_busy=0; -> IDLE.
//     RegWrite is ignored (dropped, not queued) while clr_busy=1.
//     Bypass is disabled while clr_busy=1.
//     Reads during CLEAR return current contents: already-cleared entries read 0.
//     clr_req while clr_busy=1, or in DONE, is ignored; no restart.
//     clr_req and RegWrite in the same IDLE cycle: the write commits, then the clear begins.
//       Net result is that all entries are 0.
//     rst_n low mid-clear: immediate return to IDLE, all entries 0, no clr_done pulse.
//   Widths: idx is ADDR_W bits. No arithmetic on data.
//     Address compares are full ADDR_W bits; there is no out-of-range case.
// TESTING
//   1. Reset, then read all addresses on all ports -> every ReadData = 0. clr_busy = clr_done = 0.
//   2. Write 0xDEADBEEF to addr 7, next cycle read 7 on port 0 and port 1
//      -> both 0xDEADBEEF. Write 0x1234 to addr 0 -> reads 0 (ZERO_REG=1).
//   3. BYPASS=1: RegWrite=1, addr 9, data 0xA5A5A5A5, port 0 reads 9 in the same cycle -> 0xA5A5A5A5.
//      With BYPASS=0 the old value is returned.
//   4. Fill addrs 1..31 with their index, pulse clr_req
//      -> clr_busy high for 32 cycles, clr_done pulse 1 cycle. All reads 0 afterwards.
//      A RegWrite to addr 5 mid-clear is dropped; a second clr_req mid-clear is ignored.
//   5. Start a clear, assert rst_n=0 at idx=10
//      -> clr_busy drops immediately, no clr_done, all entries 0.
//      After release, a write to addr 3 of 0x55 reads back 0x55.
//   6. NUM_RD=4, DATA_W=16, ADDR_W=3: random writes/reads for 1000 cycles against a behavioural model
//      -> zero mismatches.

Source files
------------

// File: rtl/regfile_param_if.sv
// Register file port bundle: writeback, operand reads and bulk-clear handshake.
// The master drives writes, read addresses and clear requests; the slave is the register file.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     RegWrite;
   logic [ADDR_W-1:0]        WriteRegister;
   logic [DATA_W-1:0]        WriteData;
   logic [NUM_RD*ADDR_W-1:0] ReadRegister;
   logic [NUM_RD*DATA_W-1:0] ReadData;
   logic                     clr_req;
   logic                     clr_busy;
   logic                     clr_done;

   modport master (
      output RegWrite, WriteRegister, WriteData,
      output ReadRegister, clr_req,
      input  ReadData, clr_busy, clr_done
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData,
      input  ReadRegister, clr_req,
      output ReadData, clr_busy, clr_done
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with optional zero register,
// write-to-read bypass and a one-entry-per-cycle bulk-clear engine.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   regfile_param_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } state_t;

   state_t                   state;
   logic [ADDR_W-1:0]        idx;
   logic                     busy;
   logic                     done;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic                     wr_ok;
   logic [ADDR_W-1:0]        ra;
   logic [NUM_RD*DATA_W-1:0] rdata;

   // A write is dropped while clearing and, with a zero register, to entry 0.
   assign wr_ok = bus.RegWrite && !busy &&
                  !(ZERO_REG != 0 && bus.WriteRegister == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         done <= 1'b0;
         if (wr_ok) mem[bus.WriteRegister] <= bus.WriteData;
         unique case (state)
            IDLE: begin
               if (bus.clr_req) begin
                  state <= CLEAR;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               mem[idx] <= '0;
               idx      <= idx + 1'b1;
               if (&idx) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      ra    = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra = bus.ReadRegister[p*ADDR_W +: ADDR_W];
         if (ZERO_REG != 0 && ra == '0)
            rdata[p*DATA_W +: DATA_W] = '0;
         else if (BYPASS != 0 && wr_ok && ra == bus.WriteRegister)
            rdata[p*DATA_W +: DATA_W] = bus.WriteData;
         else
            rdata[p*DATA_W +: DATA_W] = mem[ra];
      end
   end

   assign bus.ReadData = rdata;
   assign bus.clr_busy = busy;
   assign bus.clr_done = done;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed checks on the default build and
// randomized checks of a 4-port, 16-bit, 8-entry build against an array model.
module tb_regfile_param;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ia ();
   regfile_param_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) ib ();

   regfile_param ua (
      .clk   (clk),
      .rst_n (rst_a),
      .bus   (ia.slave)
   );

   regfile_param #(
      .DATA_W   (16),
      .ADDR_W   (3),
      .NUM_RD   (4),
      .ZERO_REG (0),
      .BYPASS   (0)
   ) ub (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (ib.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] pa(input int p);
      return ia.ReadData[p*32 +: 32];
   endfunction

   function automatic logic [31:0] pb(input int p);
      return 32'(ib.ReadData[p*16 +: 16]);
   endfunction

   initial begin
      int          busy_cnt;
      int          done_cnt;
      int          done_at;
      int          phase;
      logic        bexp;
      logic [15:0] mb [8];

      ia.RegWrite = 1'b0; ia.WriteRegister = '0; ia.WriteData = '0;
      ia.ReadRegister = '0; ia.clr_req = 1'b0;
      ib.RegWrite = 1'b0; ib.WriteRegister = '0; ib.WriteData = '0;
      ib.ReadRegister = '0; ib.clr_req = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick;

      // reset state
      chk("rst_busy", 32'(ia.clr_busy), 32'd0);
      chk("rst_done", 32'(ia.clr_done), 32'd0);
      for (int a = 0; a < 32; a++) begin
         ia.ReadRegister = {5'(a), 5'(a)};
         #1;
         chk("rst_rd0", pa(0), 32'd0);
         chk("rst_rd1", pa(1), 32'd0);
      end
      tick;

      // basic write/read and zero register
      ia.RegWrite = 1'b1; ia.WriteRegister = 5'd7; ia.WriteData = 32'hDEADBEEF;
      tick;
      ia.RegWrite = 1'b0; ia.ReadRegister = {5'd7, 5'd7};
      #1;
      chk("wr7_p0", pa(0), 32'hDEADBEEF);
      chk("wr7_p1", pa(1), 32'hDEADBEEF);
      ia.RegWrite = 1'b1; ia.WriteRegister = 5'd0; ia.WriteData = 32'h1234;
      ia.ReadRegister = {5'd0, 5'd0};
      #1;
      chk("zero_byp", pa(0), 32'd0);
      tick;
      ia.RegWrite = 1'b0;
      #1;
      chk("zero_rd", pa(1), 32'd0);

      // bypass on A, none on B
      ia.RegWrite = 1'b1; ia.WriteRegister = 5'd9; ia.WriteData = 32'hA5A5A5A5;
      ia.ReadRegister = {5'd7, 5'd9};
      #1;
      chk("byp_p0", pa(0), 32'hA5A5A5A5);
      chk("byp_p1", pa(1), 32'hDEADBEEF);
      tick;
      ia.RegWrite = 1'b0; ia.ReadRegister = {5'd9, 5'd9};
      #1;
      chk("wr9_p1", pa(1), 32'hA5A5A5A5);
      ib.RegWrite = 1'b1; ib.WriteRegister = 3'd5; ib.WriteData = 16'h1111;
      tick;
      ib.WriteData = 16'h2222; ib.ReadRegister = {4{3'd5}};
      #1;
      chk("nobyp_old", pb(0), 32'h1111);
      tick;
      ib.RegWrite = 1'b0;
      #1;
      chk("nobyp_new", pb(3), 32'h2222);
      ib.RegWrite = 1'b1; ib.WriteRegister = 3'd0; ib.WriteData = 16'h0BAD;
      tick;
      ib.RegWrite = 1'b0; ib.ReadRegister = {3'd0, 3'd0, 3'd0, 3'd5};
      #1;
      chk("b_reg0", pb(2), 32'h0BAD);
      tick;

      // bulk clear with dropped write and ignored re-request
      for (int a = 1; a < 32; a++) begin
         ia.RegWrite = 1'b1; ia.WriteRegister = 5'(a); ia.WriteData = 32'(a);
         tick;
      end
      ia.RegWrite = 1'b0; ia.ReadRegister = {5'd31, 5'd1};
      #1;
      chk("fill_1", pa(0), 32'd1);
      chk("fill_31", pa(1), 32'd31);
      ia.clr_req = 1'b1;
      tick;
      ia.clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 40; c++) begin
         if (ia.clr_busy) busy_cnt++;
         if (ia.clr_done) begin
            done_cnt++;
            done_at = c;
         end
         if (c == 1) chk("clr_busy_1", 32'(ia.clr_busy), 32'd1);
         if (c == 10) begin
            ia.RegWrite = 1'b1; ia.WriteRegister = 5'd5; ia.WriteData = 32'h77;
            ia.clr_req = 1'b1; ia.ReadRegister = {5'd5, 5'd20};
            #1;
            chk("clr_nobyp", pa(1), 32'd0);
            chk("clr_keep20", pa(0), 32'd20);
         end
         if (c == 11) begin
            ia.RegWrite = 1'b0; ia.clr_req = 1'b0;
            ia.ReadRegister = {5'd10, 5'd9};
            #1;
            chk("clr_prog_lo", pa(0), 32'd0);
            chk("clr_prog_hi", pa(1), 32'd10);
         end
         tick;
      end
      chk("clr_busy_cnt", 32'(busy_cnt), 32'd32);
      chk("clr_done_cnt", 32'(done_cnt), 32'd1);
      chk("clr_done_at", 32'(done_at), 32'd33);
      for (int a = 0; a < 32; a++) begin
         ia.ReadRegister = {5'd0, 5'(a)};
         #1;
         chk("clr_all", pa(0), 32'd0);
      end
      tick;

      // write and clear request in the same idle cycle
      ia.RegWrite = 1'b1; ia.WriteRegister = 5'd12; ia.WriteData = 32'hCAFE;
      ia.clr_req = 1'b1; ia.ReadRegister = {5'd0, 5'd12};
      #1;
      chk("wrclr_byp", pa(0), 32'hCAFE);
      tick;
      ia.RegWrite = 1'b0; ia.clr_req = 1'b0;
      repeat (34) tick;
      chk("wrclr_busy", 32'(ia.clr_busy), 32'd0);
      chk("wrclr_rd", pa(0), 32'd0);

      // reset in the middle of a clear
      ia.RegWrite = 1'b1; ia.WriteRegister = 5'd3; ia.WriteData = 32'h99;
      tick;
      ia.WriteRegister = 5'd20; ia.WriteData = 32'h20;
      tick;
      ia.RegWrite = 1'b0; ia.clr_req = 1'b1;
      tick;
      ia.clr_req = 1'b0;
      repeat (10) tick;
      chk("mid_busy_pre", 32'(ia.clr_busy), 32'd1);
      rst_a = 1'b0;
      #1;
      chk("mid_busy", 32'(ia.clr_busy), 32'd0);
      chk("mid_done", 32'(ia.clr_done), 32'd0);
      tick;
      rst_a = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         tick;
         if (ia.clr_done || ia.clr_busy) done_cnt++;
      end
      chk("mid_quiet", 32'(done_cnt), 32'd0);
      ia.ReadRegister = {5'd20, 5'd3};
      #1;
      chk("mid_rd3", pa(0), 32'd0);
      chk("mid_rd20", pa(1), 32'd0);
      ia.RegWrite = 1'b1; ia.WriteRegister = 5'd3; ia.WriteData = 32'h55;
      tick;
      ia.RegWrite = 1'b0;
      #1;
      chk("mid_wr3", pa(0), 32'h55);
      tick;

      // randomized run on the 4-port build
      rst_b = 1'b0;
      tick;
      rst_b = 1'b1;
      tick;
      for (int i = 0; i < 8; i++) mb[i] = '0;
      phase = -1;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         ib.RegWrite      = 1'($urandom_range(0, 1));
         ib.WriteRegister = 3'($urandom);
         ib.WriteData     = 16'($urandom);
         ib.ReadRegister  = 12'($urandom);
         ib.clr_req       = ($urandom_range(0, 39) == 0);
         #1;
         bexp = (phase >= 0 && phase < 8);
         chk("rnd_busy", 32'(ib.clr_busy), 32'(bexp));
         chk("rnd_done", 32'(ib.clr_done), 32'(phase == 8));
         for (int p = 0; p < 4; p++)
            chk("rnd_rd", pb(p), 32'(mb[ib.ReadRegister[p*3 +: 3]]));
         @(posedge clk);
         if (ib.RegWrite && !bexp) mb[ib.WriteRegister] = ib.WriteData;
         if (bexp) begin
            mb[phase] = '0;
            phase++;
         end else if (phase == 8) begin
            phase = -1;
         end else if (ib.clr_req) begin
            phase = 0;
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
